// File: rtl/pending_encoder_32to5.sv
// rtl/pending_encoder_32to5.sv - 32-line pending register with priority encoder, popcount and sticky overflow
module pending_encoder_32to5 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] set_in,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [31:0] pending,
  output logic [5:0]  pending_cnt,
  output logic        overflow
);

  logic [31:0] pending_q, pending_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  idx;
  logic        hs;
  logic [31:0] clr_mask;

  // Later loop iterations overwrite earlier ones, so scan order sets priority.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = 31; i >= 0; i--) begin
        if (pending_q[i]) idx = i[4:0];
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (pending_q[i]) idx = i[4:0];
      end
    end
  end

  assign out_valid = |pending_q;
  assign out_idx   = idx;
  assign hs        = out_valid & out_ready;
  assign clr_mask  = hs ? (32'd1 << idx) : 32'd0;

  always_comb begin
    pending_d = '0;
    ovf_d     = 1'b0;
    cnt_d     = '0;
    if (flush) begin
      pending_d = set_in;
      ovf_d     = 1'b0;
    end else begin
      pending_d = (pending_q & ~clr_mask) | set_in;
      ovf_d     = ovf_q | (|(set_in & pending_q & ~clr_mask));
    end
    for (int i = 0; i < 32; i++) begin
      cnt_d = cnt_d + 6'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending     = pending_q;
  assign pending_cnt = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/pending_encoder_32to5.md
PENDING_ENCODER_32TO5 -- requirements
Module: pending_encoder_32to5

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1: 1 = lowest pending index has priority, 0 = highest pending index has priority.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port set_in, input, 32 bits: one-cycle request pulses; bit i marks register/line i as pending.
REQ-005 SHALL have port flush, input, 1 bit: synchronous clear of all pending state.
REQ-006 SHALL have port out_ready, input, 1 bit: the consumer accepts out_idx this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: at least one bit is pending.
REQ-008 SHALL have port out_idx, output, 5 bits: encoded index of the priority pending bit.
REQ-009 SHALL have port pending, output, 32 bits: the current pending register.
REQ-010 SHALL have port pending_cnt, output, 6 bits: the number of set bits in pending (0..32).
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag; a request arrived for an already-pending bit.

Function
REQ-012 SHALL hold state in a 32-bit pending register, a 6-bit count register and a 1-bit overflow register; nothing else is stateful.
REQ-013 SHALL drive out_valid combinationally as the OR of all bits of pending.
REQ-014 SHALL drive out_idx combinationally as the priority encode of pending per LSB_FIRST, and as 5'd0 when out_valid=0.
REQ-015 SHALL define a handshake as out_valid=1 and out_ready=1 in the same cycle; clr_mask is then the one-hot decode of out_idx, otherwise clr_mask is 0.
REQ-016 SHALL compute next pending, when flush=0, as (pending AND NOT clr_mask) OR set_in.
REQ-017 SHALL compute next pending, when flush=1, as set_in; the pre-flush contents and any handshake that cycle are discarded.
REQ-018 SHALL give set_in precedence on simultaneous set and clear of the same bit, so the bit stays pending.
REQ-019 SHALL make a set_in pulse on edge N visible on pending/out_valid/out_idx after edge N (1-cycle latency); a bit cleared by a handshake disappears after that edge.
REQ-020 SHALL load pending_cnt as the popcount of next pending, so pending_cnt always matches pending in the same cycle; 32 bits pending gives 6'd32 with no wrap.
REQ-021 SHALL set overflow when flush=0 and any bit i has set_in[i]=1, pending[i]=1 and clr_mask[i]=0; overflow stays set until flush or reset.
REQ-022 SHALL clear overflow on flush=1 regardless of set_in.
REQ-023 SHALL allow out_idx to change while out_valid=1 and out_ready=0 if a higher-priority bit arrives (preemption); the consumer treats out_idx as meaningful only on a handshake.
REQ-024 SHALL retire at most one index per cycle; sustained out_ready=1 drains N pending bits in N cycles in priority order.

Reset
REQ-025 SHALL, while reset=1, asynchronously force pending=0, pending_cnt=0 and overflow=0, so that out_valid=0 and out_idx=0, independent of clk.
REQ-026 SHALL, when reset asserts mid-drain, lose all pending state; the first edge after deassertion samples set_in/flush normally.

Verification
REQ-027 SHALL be verified with: set_in=32'h8000_0011 for 1 cycle, out_ready=1 -> out_idx 0,4,31 on 3 consecutive cycles, then out_valid=0 and pending_cnt 3,2,1,0.
REQ-028 SHALL be verified with: LSB_FIRST=0, pending=32'h0000_0106, out_ready=1 -> out_idx 8,2,1.
REQ-029 SHALL be verified with: pending bit 5 with out_ready=0, then set_in bit 5 again -> overflow=1 next cycle, pending_cnt unchanged at 1.
REQ-030 SHALL be verified with: handshake on idx 3 while set_in bit 3=1 -> bit 3 remains pending and overflow stays 0.
REQ-031 SHALL be verified with: set_in=32'hFFFF_FFFF -> pending_cnt=32, and 32 cycles of out_ready=1 drain it to 0.
REQ-032 SHALL be verified with: flush=1 with set_in=32'h0000_0040 while pending=32'h0000_00FF and overflow=1 -> pending=32'h0000_0040, overflow=0, out_idx=6; asserting reset between clock edges clears all outputs immediately.
